// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline control for the 5-stage core: stall/flush controls for the F/D,
// D/E, E/M and M/W stage registers, E-stage operand forwarding selects, a
// data-memory wait FSM with timeout, and saturating stall/flush counters.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   Rs1D_i, Rs2D_i              sources of the instruction in D
//   Rs1E_i, Rs2E_i, RdE_i       sources/destination of the instruction in E
//   ResultSrcE_i                result select in E (2'b01 = load)
//   PCSrcE_i                    taken branch / jump resolved in E
//   RdM_i, RegWriteM_i          destination and write enable in M
//   RdW_i, RegWriteW_i          destination and write enable in W
//   MemReqM_i, MemReadyM_i      data memory request in M / access completes
//   StallF_o..StallM_o          hold the stage register
//   FlushD_o, FlushE_o, FlushW_o  load a bubble into the stage register
//   ForwardAE_o, ForwardBE_o    00 regfile, 01 W result, 10 M ALU result
//   MemErr_o                    sticky memory-timeout error (registered)
//   StallCycles_o, FlushCycles_o  saturating performance counters
module hazard_unit #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int WAIT_TIMEOUT           = 255,
  parameter int COUNT_WIDTH            = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic                              RegWriteM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteW_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemErr_o,
  output logic [COUNT_WIDTH-1:0]            StallCycles_o,
  output logic [COUNT_WIDTH-1:0]            FlushCycles_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT = 16'(WAIT_TIMEOUT);
  localparam logic [REGISTER_ADDRESS_WIDTH-1:0] X0 = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [15:0]              wait_cnt_q, wait_cnt_d;
  logic                     mem_err_q, mem_err_d;
  logic [COUNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [COUNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic lw_stall;
  logic hold_all;

  // Forwarding select for one E-stage source; M is newer than W so it wins.
  function automatic logic [1:0] fwd_sel(
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m,
    input logic                              we_m,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w,
    input logic                              we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != X0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != X0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard terms and forwarding selects.
  always_comb begin
    mem_stall   = MemReqM_i & ~MemReadyM_i;
    lw_stall    = (ResultSrcE_i == 2'b01) && (RdE_i != X0) &&
                  ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    // The error state freezes the pipeline exactly like an outstanding access.
    hold_all    = (state_q == ST_ERR) | mem_stall;
    ForwardAE_o = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
    ForwardBE_o = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
  end

  // Stall/flush outputs; a frozen pipeline suppresses load-use and redirect
  // handling, which re-evaluate once E is released.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (hold_all) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      StallF_o = lw_stall;
      StallD_o = lw_stall;
      FlushD_o = PCSrcE_i;
      FlushE_o = lw_stall | PCSrcE_i;
    end
  end

  // Memory-wait FSM next state and wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 16'd1;
        end else begin
          wait_cnt_d = 16'd0;
        end
      end
      ST_WAIT: begin
        if (MemReadyM_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == TIMEOUT) begin
          state_d    = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 16'd0;
      end
    endcase
  end

  // Sticky error flag and saturating counters.
  always_comb begin
    mem_err_d = mem_err_q | (state_d == ST_ERR);
    if (StallF_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (FlushD_o && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 16'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr_o      = mem_err_q;
  assign StallCycles_o = stall_cnt_q;
  assign FlushCycles_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the control rules.
module tb_hazard_unit;

  localparam int AW  = 5;
  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [AW-1:0] rs1d;
    logic [AW-1:0] rs2d;
    logic [AW-1:0] rs1e;
    logic [AW-1:0] rs2e;
    logic [AW-1:0] rde;
    logic [1:0]    rsrc;
    logic          pcsrc;
    logic [AW-1:0] rdm;
    logic          wem;
    logic [AW-1:0] rdw;
    logic          wew;
    logic          req;
    logic          rdy;
  } stim_t;

  logic  clk_i  = 1'b0;
  logic  rst_ni = 1'b0;
  stim_t cur    = '0;
  stim_t nx     = '0;

  logic          StallF_o, StallD_o, StallE_o, StallM_o;
  logic          FlushD_o, FlushE_o, FlushW_o;
  logic [1:0]    ForwardAE_o, ForwardBE_o;
  logic          MemErr_o;
  logic [CW-1:0] StallCycles_o, FlushCycles_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: error flag, length of the current memory wait,
  // and the two counters as plain integers.
  bit m_err   = 1'b0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_unit #(
    .REGISTER_ADDRESS_WIDTH(AW),
    .WAIT_TIMEOUT(TO),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .Rs1D_i(cur.rs1d), .Rs2D_i(cur.rs2d),
    .Rs1E_i(cur.rs1e), .Rs2E_i(cur.rs2e), .RdE_i(cur.rde),
    .ResultSrcE_i(cur.rsrc), .PCSrcE_i(cur.pcsrc),
    .RdM_i(cur.rdm), .RegWriteM_i(cur.wem),
    .RdW_i(cur.rdw), .RegWriteW_i(cur.wew),
    .MemReqM_i(cur.req), .MemReadyM_i(cur.rdy),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .MemErr_o(MemErr_o),
    .StallCycles_o(StallCycles_o), .FlushCycles_o(FlushCycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int fwd_ref(input int rs, input stim_t s);
    if (s.wem && s.rdm != 0 && int'(s.rdm) == rs) return 2;
    if (s.wew && s.rdw != 0 && int'(s.rdw) == rs) return 1;
    return 0;
  endfunction

  // Apply nx for one cycle, compare every output with the model, then
  // advance the model to match the coming rising edge.
  task automatic step(input string tag);
    bit mem, lw, frz;
    int sf, se, fd, fe, fw;
    @(negedge clk_i);
    cur = nx;
    #1;
    mem = cur.req && !cur.rdy;
    lw  = (cur.rsrc == 2'b01) && (cur.rde != 0) &&
          (cur.rde == cur.rs1d || cur.rde == cur.rs2d);
    frz = m_err || mem;
    sf  = frz ? 1 : int'(lw);
    se  = frz ? 1 : 0;
    fd  = frz ? 0 : int'(cur.pcsrc);
    fe  = frz ? 0 : int'(lw || cur.pcsrc);
    fw  = frz ? 1 : 0;
    check_eq({tag, ".StallF"}, int'(StallF_o), sf);
    check_eq({tag, ".StallD"}, int'(StallD_o), sf);
    check_eq({tag, ".StallE"}, int'(StallE_o), se);
    check_eq({tag, ".StallM"}, int'(StallM_o), se);
    check_eq({tag, ".FlushD"}, int'(FlushD_o), fd);
    check_eq({tag, ".FlushE"}, int'(FlushE_o), fe);
    check_eq({tag, ".FlushW"}, int'(FlushW_o), fw);
    check_eq({tag, ".FwdA"}, int'(ForwardAE_o), fwd_ref(int'(cur.rs1e), cur));
    check_eq({tag, ".FwdB"}, int'(ForwardBE_o), fwd_ref(int'(cur.rs2e), cur));
    check_eq({tag, ".MemErr"}, int'(MemErr_o), int'(m_err));
    check_eq({tag, ".StallCnt"}, int'(StallCycles_o), m_stall);
    check_eq({tag, ".FlushCnt"}, int'(FlushCycles_o), m_flush);
    if (sf == 1 && m_stall < CMAX) m_stall++;
    if (fd == 1 && m_flush < CMAX) m_flush++;
    // Wait length counts consecutive not-ready cycles; the error occurs
    // on the (TO+1)-th one.
    if (!m_err) begin
      if (m_wait == 0) begin
        if (mem) m_wait = 1;
      end else if (cur.rdy) begin
        m_wait = 0;
      end else if (m_wait == TO) begin
        m_err  = 1'b1;
      end else begin
        m_wait++;
      end
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk_i);
    nx     = '0;
    cur    = '0;
    rst_ni = 1'b0;
    #1;
    m_err = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
    check_eq({tag, ".rst_StallF"}, int'(StallF_o), 0);
    check_eq({tag, ".rst_StallE"}, int'(StallE_o), 0);
    check_eq({tag, ".rst_FlushW"}, int'(FlushW_o), 0);
    check_eq({tag, ".rst_MemErr"}, int'(MemErr_o), 0);
    check_eq({tag, ".rst_StallCnt"}, int'(StallCycles_o), 0);
    check_eq({tag, ".rst_FlushCnt"}, int'(FlushCycles_o), 0);
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset("init");

    // Load-use hazard, then the same with RdE = x0.
    nx = '0; nx.rsrc = 2'b01; nx.rde = 5'd5; nx.rs1d = 5'd5;
    step("lu");
    check_eq("lu.StallF_1", int'(StallF_o), 1);
    check_eq("lu.FlushE_1", int'(FlushE_o), 1);
    check_eq("lu.FlushD_0", int'(FlushD_o), 0);
    nx.rde = 5'd0; nx.rs1d = 5'd0;
    step("lu_x0");
    check_eq("lu_x0.StallF_0", int'(StallF_o), 0);

    // Forward priority M over W, then W only, then x0.
    nx = '0; nx.wem = 1'b1; nx.wew = 1'b1; nx.rdm = 5'd7; nx.rdw = 5'd7; nx.rs1e = 5'd7;
    step("fwd_m");
    check_eq("fwd_m.A_10", int'(ForwardAE_o), 2);
    nx.wem = 1'b0;
    step("fwd_w");
    check_eq("fwd_w.A_01", int'(ForwardAE_o), 1);
    nx.wem = 1'b1; nx.rdm = 5'd0; nx.rdw = 5'd0; nx.rs1e = 5'd0;
    step("fwd_x0");
    check_eq("fwd_x0.A_00", int'(ForwardAE_o), 0);

    // Branch redirect for one cycle.
    nx = '0; nx.pcsrc = 1'b1;
    step("br");
    check_eq("br.FlushD_1", int'(FlushD_o), 1);
    nx = '0;
    step("br_after");
    check_eq("br.FlushCnt_1", int'(FlushCycles_o), 1);

    // Memory wait of 3 cycles with a pending redirect, then ready.
    do_reset("mw");
    nx = '0; nx.req = 1'b1; nx.pcsrc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("mw_wait");
      check_eq("mw.StallM_1", int'(StallM_o), 1);
      check_eq("mw.FlushD_0", int'(FlushD_o), 0);
    end
    nx.rdy = 1'b1;
    step("mw_ready");
    check_eq("mw.ready_FlushD_1", int'(FlushD_o), 1);
    check_eq("mw.StallCnt_3", int'(StallCycles_o), 3);
    nx = '0;
    step("mw_run");
    check_eq("mw.run_StallE_0", int'(StallE_o), 0);

    // Timeout: error after TO+1 not-ready cycles, sticky, cleared by reset.
    do_reset("to");
    nx = '0; nx.req = 1'b1;
    for (int i = 0; i < TO + 1; i++) step("to_wait");
    check_eq("to.MemErr_before", int'(MemErr_o), 0);
    nx.rdy = 1'b1;
    step("to_err");
    check_eq("to.MemErr_1", int'(MemErr_o), 1);
    check_eq("to.err_StallF_1", int'(StallF_o), 1);
    nx = '0;
    step("to_sticky");
    check_eq("to.MemErr_sticky", int'(MemErr_o), 1);
    do_reset("to_clr");

    // Counter saturation at 2^CW-1.
    nx = '0; nx.req = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    nx = '0;
    step("sat_end");
    check_eq("sat.StallCnt_max", int'(StallCycles_o), CMAX);

    // Randomized traffic with occasional resets.
    do_reset("rnd");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
      nx.rs1d  = AW'($urandom_range(0, 3));
      nx.rs2d  = AW'($urandom_range(0, 3));
      nx.rs1e  = AW'($urandom_range(0, 3));
      nx.rs2e  = AW'($urandom_range(0, 3));
      nx.rde   = AW'($urandom_range(0, 3));
      nx.rdm   = AW'($urandom_range(0, 3));
      nx.rdw   = AW'($urandom_range(0, 3));
      nx.rsrc  = 2'($urandom_range(0, 3));
      nx.pcsrc = ($urandom_range(0, 3) == 0);
      nx.wem   = 1'($urandom_range(0, 1));
      nx.wew   = 1'($urandom_range(0, 1));
      nx.req   = ($urandom_range(0, 2) == 0);
      nx.rdy   = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
